bresenham_line: RTL and testbench

Line-drawing engine that answers the rasterizer control unit's bresen_start/bresen_done handshake. It takes two endpoints and emits every pixel of the Bresenham line from p to q, one pixel per accepted handshake, toward the framebuffer writer. When the last pixel has been accepted it pulses done for one cycle, so the controller can advance to the next triangle edge.

---
 rtl/defines_package.sv | 43 ++++
 rtl/bresenham_line.sv | 163 ++++++++++++++++
 tb/tb_bresenham_line.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/defines_package.sv
// Shared geometry types and constants for the rasterizer and the line engine.
package defines_package;

    localparam int COORD_W = 10;
    localparam int ERR_W   = COORD_W + 2;
    localparam int E2_W    = COORD_W + 3;

    localparam logic [COORD_W-1:0] COORD_ONE = {{(COORD_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } Point2D;

    typedef struct packed {
        Point2D a;
        Point2D b;
        Point2D c;
    } Triangle2D;

    // Line engine FSM states, exposed so benches can probe the engine.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        PLOT = 2'd2,
        DONE = 2'd3
    } line_state_e;

    // Magnitude of the difference of two unsigned coordinates.
    function automatic logic [COORD_W-1:0] coord_abs_diff(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        logic [COORD_W-1:0] d;
        if (a > b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

endpackage

// File: rtl/bresenham_line.sv
// Bresenham line engine: latches two endpoints on start, then streams every
// pixel from p to q over a valid/ready interface and pulses done once.
module bresenham_line
    import defines_package::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  Point2D p,
    input  Point2D q,
    output Point2D pixel,
    output logic   pixel_valid,
    input  logic   pixel_ready,
    output logic   busy,
    output logic   done
);

    line_state_e state_r, state_nx_s;

    Point2D start_r, start_nx_s;
    Point2D end_r,   end_nx_s;
    Point2D cur_r,   cur_nx_s;

    logic signed [ERR_W-1:0] dx_r,  dx_nx_s;
    logic signed [ERR_W-1:0] dy_r,  dy_nx_s;
    logic signed [ERR_W-1:0] err_r, err_nx_s;
    logic signed [ERR_W-1:0] err_dx_term_s, err_dy_term_s;

    logic sx_neg_r, sx_neg_nx_s;
    logic sy_neg_r, sy_neg_nx_s;

    logic signed [E2_W-1:0] e2_s, dx_ext_s, dy_ext_s;
    logic step_x_s, step_y_s, at_end_s;

    Point2D pixel_r;
    logic   pixel_valid_r, busy_r, done_r;

    // e2 = 2*err fits exactly in one extra bit; dx/dy are sign-extended to match.
    assign e2_s     = $signed({err_r, 1'b0});
    assign dx_ext_s = $signed({dx_r[ERR_W-1], dx_r});
    assign dy_ext_s = $signed({dy_r[ERR_W-1], dy_r});
    assign step_x_s = (e2_s >= dy_ext_s);
    assign step_y_s = (e2_s <= dx_ext_s);
    assign at_end_s = (cur_r == end_r);

    assign pixel       = pixel_r;
    assign pixel_valid = pixel_valid_r;
    assign busy        = busy_r;
    assign done        = done_r;

    // Next-state and step datapath; every register holds unless its state moves it.
    always_comb begin
        state_nx_s    = state_r;
        start_nx_s    = start_r;
        end_nx_s      = end_r;
        cur_nx_s      = cur_r;
        dx_nx_s       = dx_r;
        dy_nx_s       = dy_r;
        err_nx_s      = err_r;
        sx_neg_nx_s   = sx_neg_r;
        sy_neg_nx_s   = sy_neg_r;
        err_dx_term_s = {ERR_W{1'b0}};
        err_dy_term_s = {ERR_W{1'b0}};

        case (state_r)
            IDLE: begin
                if (start) begin
                    start_nx_s = p;
                    end_nx_s   = q;
                    state_nx_s = INIT;
                end else begin
                    state_nx_s = IDLE;
                end
            end

            INIT: begin
                dx_nx_s     = $signed({2'b00, coord_abs_diff(start_r.x, end_r.x)});
                dy_nx_s     = -$signed({2'b00, coord_abs_diff(start_r.y, end_r.y)});
                err_nx_s    = dx_nx_s + dy_nx_s;
                sx_neg_nx_s = !(start_r.x < end_r.x);
                sy_neg_nx_s = !(start_r.y < end_r.y);
                cur_nx_s    = start_r;
                state_nx_s  = PLOT;
            end

            PLOT: begin
                if (pixel_ready) begin
                    if (at_end_s) begin
                        state_nx_s = DONE;
                    end else begin
                        // X and Y steps are independent; a diagonal step applies both.
                        if (step_x_s) begin
                            err_dy_term_s = dy_r;
                            if (sx_neg_r) begin
                                cur_nx_s.x = cur_r.x - COORD_ONE;
                            end else begin
                                cur_nx_s.x = cur_r.x + COORD_ONE;
                            end
                        end else begin
                            cur_nx_s.x = cur_r.x;
                        end
                        if (step_y_s) begin
                            err_dx_term_s = dx_r;
                            if (sy_neg_r) begin
                                cur_nx_s.y = cur_r.y - COORD_ONE;
                            end else begin
                                cur_nx_s.y = cur_r.y + COORD_ONE;
                            end
                        end else begin
                            cur_nx_s.y = cur_r.y;
                        end
                        err_nx_s   = err_r + err_dy_term_s + err_dx_term_s;
                        state_nx_s = PLOT;
                    end
                end else begin
                    state_nx_s = PLOT;
                end
            end

            DONE: begin
                state_nx_s = IDLE;
            end

            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; outputs decode the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            start_r       <= {(2*COORD_W){1'b0}};
            end_r         <= {(2*COORD_W){1'b0}};
            cur_r         <= {(2*COORD_W){1'b0}};
            dx_r          <= {ERR_W{1'b0}};
            dy_r          <= {ERR_W{1'b0}};
            err_r         <= {ERR_W{1'b0}};
            sx_neg_r      <= 1'b0;
            sy_neg_r      <= 1'b0;
            pixel_r       <= {(2*COORD_W){1'b0}};
            pixel_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            start_r       <= start_nx_s;
            end_r         <= end_nx_s;
            cur_r         <= cur_nx_s;
            dx_r          <= dx_nx_s;
            dy_r          <= dy_nx_s;
            err_r         <= err_nx_s;
            sx_neg_r      <= sx_neg_nx_s;
            sy_neg_r      <= sy_neg_nx_s;
            pixel_r       <= cur_nx_s;
            pixel_valid_r <= (state_nx_s == PLOT);
            busy_r        <= (state_nx_s != IDLE);
            done_r        <= (state_nx_s == DONE);
        end
    end

endmodule

// File: tb/tb_bresenham_line.sv
// Self-checking bench for bresenham_line against an integer Bresenham model.
module tb_bresenham_line;
    import defines_package::*;

    logic   clk;
    logic   rst;
    logic   start;
    Point2D p, q, pixel;
    logic   pixel_valid, pixel_ready, busy, done;

    int n_checks = 0;
    int n_errors = 0;
    int done_total = 0;
    int pix_total = 0;

    Point2D exp_q[$];
    int     exp_err[$];

    bresenham_line dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .p           (p),
        .q           (q),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint obs, input longint exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic Point2D mk(input int x, input int y);
        Point2D pt;
        pt.x = COORD_W'(x);
        pt.y = COORD_W'(y);
        return pt;
    endfunction

    function automatic Point2D rand_point(input int max_c);
        return mk(int'($urandom_range(0, max_c)), int'($urandom_range(0, max_c)));
    endfunction

    // Textbook Bresenham in plain integers: pixel list and err seen at each pixel.
    task automatic model_line(input Point2D a, input Point2D b);
        int x, y, x1, y1, dx, dy, sx, sy, err, e2;
        bit fin;
        x  = int'(a.x);
        y  = int'(a.y);
        x1 = int'(b.x);
        y1 = int'(b.y);
        dx = (x1 > x) ? (x1 - x) : (x - x1);
        dy = (y1 > y) ? (y - y1) : (y1 - y);
        sx = (x < x1) ? 1 : -1;
        sy = (y < y1) ? 1 : -1;
        err = dx + dy;
        exp_q.delete();
        exp_err.delete();
        fin = 1'b0;
        while (!fin && exp_q.size() < 4096) begin
            exp_q.push_back(mk(x, y));
            exp_err.push_back(err);
            if (x == x1 && y == y1) begin
                fin = 1'b1;
            end else begin
                e2 = 2 * err;
                if (e2 >= dy) begin
                    err += dy;
                    x += sx;
                end
                if (e2 <= dx) begin
                    err += dx;
                    y += sy;
                end
            end
        end
    endtask

    // Start one line in the current cycle and follow it to the cycle after done.
    task automatic run_line(input Point2D a, input Point2D b, input int ready_pct,
                            input bit poke, input int stall_idx);
        int n, idx, cyc, first_valid, done_cyc, stall_cnt, limit;
        bit fin;
        model_line(a, b);
        n = exp_q.size();
        limit = 8 * n + 60;
        p = a;
        q = b;
        start = 1'b1;
        pixel_ready = 1'b1;
        tick();
        cyc = 1;
        start = 1'b0;
        p = rand_point(1023);
        q = rand_point(1023);
        check_val("init_busy", longint'(busy), 1);
        check_val("init_valid", longint'(pixel_valid), 0);
        idx = 0;
        first_valid = -1;
        done_cyc = -1;
        stall_cnt = 0;
        fin = 1'b0;
        while (!fin) begin
            if (done) begin
                done_cyc = cyc;
                done_total++;
                check_val("pixel_count", idx, n);
                check_val("valid_in_done", longint'(pixel_valid), 0);
                fin = 1'b1;
            end else begin
                if (pixel_valid) begin
                    if (first_valid < 0) first_valid = cyc;
                    if (idx < n) check_val("pixel", longint'(pixel), longint'(exp_q[idx]));
                    else check_val("extra_pixel", idx, n - 1);
                end
                if (pixel_valid && idx == stall_idx && stall_cnt < 3) begin
                    pixel_ready = 1'b0;
                    stall_cnt++;
                    check_val("err_hold", longint'(dut.err_r), exp_err[idx]);
                end else if (ready_pct >= 100) begin
                    pixel_ready = 1'b1;
                end else begin
                    pixel_ready = ($urandom_range(0, 99) < ready_pct);
                end
                start = poke && (cyc == 3);
                if (pixel_valid && pixel_ready) begin
                    idx++;
                    pix_total++;
                end
                if (cyc >= limit) begin
                    check_val("timeout", cyc, limit - 1);
                    fin = 1'b1;
                end else begin
                    tick();
                    cyc++;
                end
            end
        end
        start = 1'b0;
        pixel_ready = 1'b1;
        if (ready_pct >= 100 && stall_idx < 0 && done_cyc > 0) begin
            check_val("first_valid_cyc", first_valid, 2);
            check_val("done_cyc", done_cyc, 2 + n);
        end
        tick();
        check_val("done_single", longint'(done), 0);
        check_val("idle_after", longint'(busy), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_pix;
        rst = 1'b1;
        start = 1'b0;
        pixel_ready = 1'b1;
        p = mk(0, 0);
        q = mk(0, 0);
        tick();
        tick();
        check_val("rst_valid", longint'(pixel_valid), 0);
        check_val("rst_busy", longint'(busy), 0);
        check_val("rst_done", longint'(done), 0);
        check_val("rst_pixel", longint'(pixel), 0);
        check_val("rst_state", longint'(dut.state_r), longint'(IDLE));
        rst = 1'b0;
        tick();

        run_line(mk(0, 0), mk(5, 0), 100, 1'b0, -1);
        run_line(mk(2, 2), mk(0, 6), 100, 1'b0, -1);
        run_line(mk(7, 3), mk(7, 3), 100, 1'b0, -1);
        run_line(mk(0, 0), mk(3, 3), 100, 1'b0, 1);
        run_line(mk(1, 9), mk(12, 2), 100, 1'b1, -1);
        run_line(mk(4, 4), mk(4, 4), 100, 1'b1, -1);

        // Reset in the middle of PLOT, then a clean line.
        p = mk(0, 0);
        q = mk(20, 7);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_val("plot_before_rst", longint'(pixel_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("midrst_valid", longint'(pixel_valid), 0);
        check_val("midrst_busy", longint'(busy), 0);
        check_val("midrst_done", longint'(done), 0);
        check_val("midrst_state", longint'(dut.state_r), longint'(IDLE));
        run_line(mk(3, 8), mk(9, 1), 100, 1'b0, -1);

        // Triangle edges back to back, each start in the cycle after the previous done.
        done_total = 0;
        base_pix = pix_total;
        run_line(mk(0, 0), mk(4, 0), 100, 1'b0, -1);
        run_line(mk(4, 0), mk(0, 4), 100, 1'b0, -1);
        run_line(mk(0, 4), mk(0, 0), 100, 1'b0, -1);
        check_val("tri_dones", done_total, 3);
        check_val("tri_pixels", pix_total - base_pix, 15);

        // Random short lines under random backpressure.
        for (int i = 0; i < 12; i++) begin
            run_line(rand_point(31), rand_point(31), 60, 1'b0, -1);
        end
        // Full-range boundary lines.
        run_line(mk(0, 0), mk(1023, 1023), 100, 1'b0, -1);
        run_line(mk(1023, 0), mk(0, 1023), 100, 1'b0, -1);
        run_line(mk(1023, 17), mk(0, 600), 70, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
